// File: rtl/scara_trig_pkg.sv
// Shared constants and types for the SCARA trig path: CORDIC arctangent table,
// gain compensation, binary-angle (BAM) landmarks and the sin/cos FSM states.
package scara_trig_pkg;

  localparam int ZW    = 17;  // signed BAM residual-angle width
  localparam int IDX_W = 4;   // micro-rotation index width (ITER <= 16)
  localparam int OW    = 15;  // signed Q1.13 output width

  // atan(2^-i) in BAM units (0x10000 = 2*pi), rounded to nearest
  localparam logic signed [ZW-1:0] ATAN_LUT [16] = '{
    17'sd8192, 17'sd4836, 17'sd2555, 17'sd1297,
    17'sd651,  17'sd326,  17'sd163,  17'sd81,
    17'sd41,   17'sd20,   17'sd10,   17'sd5,
    17'sd3,    17'sd1,    17'sd1,    17'sd0
  };

  // Inverse CORDIC gain 0.607253 in Q1.13, preloaded into x so no post-scale is needed
  localparam int CORDIC_KINV = 4975;
  localparam int Q13_ONE     = 8192;

  localparam logic [15:0] BAM_HALF_PI = 16'h4000;
  localparam logic [15:0] BAM_PI      = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    DONE
  } state_t;

endpackage

// File: rtl/cordic_sincos_if.sv
// Handshake bundle for cordic_sincos: angle in (valid/ready), sin/cos out (valid/ready).
// With SINCOS_ANGLE_SUM_EN defined a second angle theta_b is carried for theta1+theta2.
interface cordic_sincos_if;
  import scara_trig_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          theta_a;
`ifdef SINCOS_ANGLE_SUM_EN
  logic [15:0]          theta_b;
`endif
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] sin_out;
  logic signed [OW-1:0] cos_out;

  modport master (
    output in_valid, theta_a,
`ifdef SINCOS_ANGLE_SUM_EN
    theta_b,
`endif
    output out_ready,
    input  in_ready, out_valid, sin_out, cos_out
  );

  modport slave (
    input  in_valid, theta_a,
`ifdef SINCOS_ANGLE_SUM_EN
    theta_b,
`endif
    input  out_ready,
    output in_ready, out_valid, sin_out, cos_out
  );

endinterface

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation in rotation mode: steers toward z = 0.
module cordic_stage
  import scara_trig_pkg::*;
#(
  parameter int IW = 18
) (
  input  logic signed [IW-1:0]    x,
  input  logic signed [IW-1:0]    y,
  input  logic signed [ZW-1:0]    z,
  input  logic        [IDX_W-1:0] i,
  output logic signed [IW-1:0]    x_nxt,
  output logic signed [IW-1:0]    y_nxt,
  output logic signed [ZW-1:0]    z_nxt
);

  logic signed [IW-1:0] x_sh;
  logic signed [IW-1:0] y_sh;

  // Rotate by +/- atan(2^-i); the sign of z picks the direction
  always_comb begin
    // NOTE: every output is assigned on every path through this block so no latch is inferred.
    x_sh = x >>> i;
    y_sh = y >>> i;
    if (!z[ZW-1]) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - ATAN_LUT[i];
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + ATAN_LUT[i];
    end
  end

endmodule

// File: rtl/cordic_sincos.sv
// Iterative CORDIC sin/cos generator feeding the jacobian stage. One micro-rotation
// per clock, one angle in flight. Angles in [pi/2, 3pi/2) are folded by pi and the
// result negated. Optional build macro SINCOS_ANGLE_SUM_EN adds theta_b and
// rotates by (theta_a + theta_b) mod 2^16.
module cordic_sincos
  import scara_trig_pkg::*;
#(
  parameter int ITER = 14,
  parameter int IW   = 18
) (
  input  logic            clk,
  input  logic            reset,
  cordic_sincos_if.slave  sc
);

  localparam logic signed [OW-1:0] OUT_HI = OW'(Q13_ONE);
  localparam logic signed [OW-1:0] OUT_LO = -OUT_HI;
  localparam logic signed [IW-1:0] SAT_HI = IW'(Q13_ONE);
  localparam logic signed [IW-1:0] SAT_LO = -SAT_HI;

  state_t               state, state_nxt;
  logic signed [IW-1:0] x, y, x_nxt, y_nxt, x_fix, y_fix;
  logic signed [ZW-1:0] z, z_nxt, z_load;
  logic [IDX_W-1:0]     i;
  logic                 flip, flip_load;
  logic [15:0]          angle;
  logic signed [OW-1:0] sin_q, cos_q, sin_sat, cos_sat;
  logic                 in_ready, out_valid, accept, last;

  function automatic logic signed [OW-1:0] sat_q13(input logic signed [IW-1:0] v);
    if (v > SAT_HI)      return OUT_HI;
    else if (v < SAT_LO) return OUT_LO;
    else                 return v[OW-1:0];
  endfunction

`ifdef SINCOS_ANGLE_SUM_EN
  assign angle = sc.theta_a + sc.theta_b;
`else
  assign angle = sc.theta_a;
`endif

  // Fold the angle into [-pi/2, pi/2) so it lies inside the CORDIC convergence range
  always_comb begin
    flip_load = (angle - BAM_HALF_PI) < BAM_PI;
    if (flip_load) z_load = ZW'({1'b0, angle}) - ZW'({1'b0, BAM_PI});
    else           z_load = {angle[15], angle};
  end

  cordic_stage #(.IW(IW)) u_stage (
    .x     (x),
    .y     (y),
    .z     (z),
    .i     (i),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt),
    .z_nxt (z_nxt)
  );

  // Undo the fold and clamp the final rotation to [-1.0, +1.0]
  always_comb begin
    x_fix   = flip ? -x_nxt : x_nxt;
    y_fix   = flip ? -y_nxt : y_nxt;
    cos_sat = sat_q13(x_fix);
    sin_sat = sat_q13(y_fix);
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (sc.in_valid) state_nxt = ROTATE;
      end
      ROTATE: begin
        if (i == IDX_W'(ITER - 1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (sc.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && sc.in_valid;
  assign last   = (state == ROTATE) && (i == IDX_W'(ITER - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath: load on accept, iterate in ROTATE, capture saturated result on the last step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x     <= '0;
      y     <= '0;
      z     <= '0;
      i     <= '0;
      flip  <= 1'b0;
      sin_q <= '0;
      cos_q <= '0;
    end else if (accept) begin
      x    <= IW'(CORDIC_KINV);
      y    <= '0;
      z    <= z_load;
      i    <= '0;
      flip <= flip_load;
    end else if (state == ROTATE) begin
      x <= x_nxt;
      y <= y_nxt;
      z <= z_nxt;
      i <= i + 1'b1;
      if (last) begin
        sin_q <= sin_sat;
        cos_q <= cos_sat;
      end
    end
  end

  assign sc.in_ready  = in_ready;
  assign sc.out_valid = out_valid;
  assign sc.sin_out   = sin_q;
  assign sc.cos_out   = cos_q;

endmodule

// File: tb/tb_cordic_sincos.sv
// Scoreboard bench for cordic_sincos: expected sin/cos come from real-valued math
// when an angle is accepted and are compared when the result handshake happens.
module tb_cordic_sincos;
  import scara_trig_pkg::*;

  localparam int  ITER = 14;
  localparam int  TOL  = 3;
  localparam real PI   = 3.14159265358979;

  typedef struct {
    string tag;
    int    s;
    int    c;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  cordic_sincos_if sc ();

  cordic_sincos #(.ITER(ITER), .IW(18)) dut (
    .clk   (clk),
    .reset (reset),
    .sc    (sc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp, input int tol);
    int diff;
    n_checks++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff <= tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
  endtask

  function automatic int q13(input real v);
    return $rtoi(v * 8192.0 + ((v >= 0.0) ? 0.5 : -0.5));
  endfunction

  // Result monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    if (reset && sc.out_valid && sc.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_sin"}, int'(sc.sin_out), e.s, TOL);
        check({e.tag, "_cos"}, int'(sc.cos_out), e.c, TOL);
      end
    end
  end

  // Present an angle, wait for acceptance, push its expectation, then time out_valid.
  // Called just after a rising edge.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input string tag);
    logic [15:0] ang;
    logic        rdy, accepted;
    int          lat;
    real         rad;
    exp_t        e;
    sc.in_valid = 1'b1;
    sc.theta_a  = ta;
`ifdef SINCOS_ANGLE_SUM_EN
    sc.theta_b  = tb;
    ang = ta + tb;
`else
    ang = ta;
`endif
    accepted = 1'b0;
    for (int k = 0; k < 100 && !accepted; k++) begin
      @(negedge clk);
      rdy = sc.in_ready;
      @(posedge clk);
      accepted = rdy;
    end
    #1 sc.in_valid = 1'b0;
    if (!accepted) begin
      check({tag, "_accept_timeout"}, 0, 1, 0);
    end else begin
      rad   = 2.0 * PI * real'(ang) / 65536.0;
      e.tag = tag;
      e.s   = q13($sin(rad));
      e.c   = q13($cos(rad));
      sb.push_back(e);
      // cycles counted from the accept cycle until out_valid is seen
      lat = 1;
      @(negedge clk);
      while (!sc.out_valid && lat < 100) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      check({tag, "_latency"}, lat, ITER + 1, 0);
    end
  endtask

  initial begin
    int held_sin, held_cos;
    sc.in_valid  = 1'b0;
    sc.theta_a   = '0;
`ifdef SINCOS_ANGLE_SUM_EN
    sc.theta_b   = '0;
`endif
    sc.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  int'(sc.in_ready),  1, 0);
    check("rst_out_valid", int'(sc.out_valid), 0, 0);
    check("rst_sin",       int'(sc.sin_out),   0, 0);
    check("rst_cos",       int'(sc.cos_out),   0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst_in_ready", int'(sc.in_ready), 1, 0);
    @(posedge clk);
    #1;

    // Main angle table, out_ready held high
    send(16'h0000, 16'h0000, "a0000");
    send(16'h2000, 16'h0000, "a2000");
    send(16'h4000, 16'h0000, "a4000");
    send(16'h8000, 16'h0000, "a8000");
    send(16'hE000, 16'h0000, "aE000");
    send(16'hC000, 16'h0000, "aC000");
    send(16'h6000, 16'h0000, "a6000");
    send(16'hBFFF, 16'h0000, "aBFFF");
`ifdef SINCOS_ANGLE_SUM_EN
    send(16'hC000, 16'h6000, "sum_wrap");
    send(16'h1000, 16'h3000, "sum_4000");
`endif

    // Backpressure: hold the result for 10 cycles while a new angle waits
    @(posedge clk);
    #1 sc.out_ready = 1'b0;
    send(16'h2000, 16'h0000, "bp_first");
    held_sin = int'(sc.sin_out);
    held_cos = int'(sc.cos_out);
    @(posedge clk);
    #1;
    sc.in_valid = 1'b1;
    sc.theta_a  = 16'h8000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_out_valid", int'(sc.out_valid), 1, 0);
      check("bp_in_ready",  int'(sc.in_ready),  0, 0);
      check("bp_sin_hold",  int'(sc.sin_out),   held_sin, 0);
      check("bp_cos_hold",  int'(sc.cos_out),   held_cos, 0);
      @(posedge clk);
      #1;
    end
    sc.out_ready = 1'b1;
    send(16'h8000, 16'h0000, "bp_second");

    // Reset during ROTATE discards the partial result
    @(posedge clk);
    #1;
    send_abort();

    // Wait for the scoreboard to drain
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
    check("sb_drained", sb.size(), 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Accept an angle, pull reset at accept+5, then confirm recovery with 0x4000
  task automatic send_abort();
    logic rdy;
    sc.in_valid = 1'b1;
    sc.theta_a  = 16'h2000;
`ifdef SINCOS_ANGLE_SUM_EN
    sc.theta_b  = 16'h0000;
`endif
    rdy = 1'b0;
    for (int k = 0; k < 100 && !rdy; k++) begin
      @(negedge clk);
      rdy = sc.in_ready;
      @(posedge clk);
    end
    #1 sc.in_valid = 1'b0;
    check("abort_accept", int'(rdy), 1, 0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_out_valid", int'(sc.out_valid), 0, 0);
    check("abort_in_ready",  int'(sc.in_ready),  1, 0);
    check("abort_sin",       int'(sc.sin_out),   0, 0);
    check("abort_cos",       int'(sc.cos_out),   0, 0);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_rel_in_ready", int'(sc.in_ready), 1, 0);
    repeat (2) begin
      @(negedge clk);
      check("abort_no_output", int'(sc.out_valid), 0, 0);
    end
    @(posedge clk);
    #1;
    send(16'h4000, 16'h0000, "after_abort");
  endtask

endmodule

// File: doc/cordic_sincos.md
Name: cordic_sincos

Overview:
- Iterative CORDIC sine/cosine generator. Directly upstream of the jacobian stage.
- Takes a joint angle, or the sum theta1+theta2, as a binary angle and produces signed fixed-point sin/cos.
- The jacobian stage scales these by l1/l2 to form dx/dth and dy/dth.
- Valid/ready handshake on both sides. One rotation per clock; one angle in flight at a time.

Parameters:
- ITER, 14, number of CORDIC micro-rotations (legal range 8..16).
- IW, 18, internal x/y datapath width (2 guard bits above output Q1.13 plus sign headroom).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  angle presented.
- in_ready  out  1  block idle, can accept.
- theta_a  in  16  unsigned binary angle; 0x10000 = 2*pi, so 0x4000 = pi/2.
- out_valid  out  1  sin/cos results valid.
- out_ready  in  1  consumer takes the result.
- sin_out  out  15  signed Q1.13 sine; 8192 = +1.0.
- cos_out  out  15  signed Q1.13 cosine.

Behaviour:
- Reset (reset=0, async): state=IDLE, in_ready=1 from the first post-reset cycle, out_valid=0, sin_out=0, cos_out=0, iteration counter=0.
- FSM states: IDLE, ROTATE, DONE.

IDLE:
- in_ready=1.
- Accept on in_valid & in_ready.
- Quadrant fold: if angle is in [0x4000, 0xC000), z = angle - 0x8000 and flip=1; else z = angle and flip=0.
- z is held as 17-bit signed BAM; folded range is [-pi/2, pi/2).
- Load x = CORDIC_KINV (0.607253 * 2^13 = 4975, sign-extended to IW), y = 0, i = 0.
- Go to ROTATE.

ROTATE:
- in_ready=0.
- Each cycle: d = (z >= 0) ? +1 : -1.
  - x <= x - d*(y >>> i)
  - y <= y + d*(x >>> i)
  - z <= z - d*ATAN_LUT[i]
  - i <= i + 1
- Shifts are arithmetic.
- After the cycle with i == ITER-1, go to DONE.
- Output registers load in that same transition: negate x/y if flip=1, then saturate to [-8192, +8192].

DONE:
- out_valid=1. sin_out/cos_out stay stable until out_valid & out_ready.
- On handshake go to IDLE.
- in_ready stays 0 in DONE, so there is no accept/complete overlap.

Timing and boundary cases:
- Latency: out_valid rises exactly ITER+1 clocks after the accepting edge. Throughput: one result per ITER+2 clocks with out_ready held high.
- in_valid while busy is ignored; upstream must hold it.
- Angle wrap is inherent in 16-bit modulo arithmetic.
- 0x4000 folds to z = -0x4000 (-pi/2) with flip=1. This is legal: CORDIC convergence range is about ±1.74 rad.
- reset asserted mid-ROTATE or in DONE aborts immediately to the reset state; the partial result is discarded.
- Accuracy: |error| <= 3 LSB of Q1.13 for ITER=14.

Optional Feature:
Macro SINCOS_ANGLE_SUM_EN.
- Defined: adds port theta_b (in, 16). The accepted angle is (theta_a + theta_b) mod 2^16, computed combinationally before the fold. This directly yields sin/cos(theta1+theta2) for the jacobian.
- Undefined: theta_b port is absent; the angle is theta_a alone.
- Latency is identical in both builds.

Decomposition:
- Package scara_trig_pkg holds:
  - ATAN_LUT: 16 entries, atan(2^-i) in BAM units, 17-bit signed, round-to-nearest; i=0 entry = 0x2000.
  - CORDIC_KINV = 4975.
  - BAM_HALF_PI = 0x4000, BAM_PI = 0x8000.
  - Q13_ONE = 8192.
  - FSM state enum typedef.
- One natural sub-module: cordic_stage, a combinational single micro-rotation (x, y, z, i in; next x, y, z out).
- The top holds the FSM, fold, registers and saturation.

Test Plan:
- theta_a=0x0000, out_ready=1 -> out_valid at accept+ITER+1; cos_out=8192±3, sin_out=0±3.
- theta_a=0x2000 (pi/4) -> sin_out=5793±3, cos_out=5793±3. theta_a=0x4000 -> sin_out=8192±3, cos_out=0±3.
- theta_a=0x8000 -> cos_out=-8192±3, sin_out=0±3. theta_a=0xE000 (-pi/4) -> sin_out=-5793±3, cos_out=5793±3.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0; a new in_valid is not accepted until the handshake.
- Drop reset low during ROTATE (accept+5) -> out_valid=0, outputs 0, in_ready=1 after release. Next angle 0x4000 gives correct sin=8192±3.
- With SINCOS_ANGLE_SUM_EN: theta_a=0xC000, theta_b=0x6000 -> wrapped sum 0x2000 -> sin_out=cos_out=5793±3.
